// File: rtl/pattern_spi_streamer.sv
// Plays a host-written pattern RAM out as framed SPI transfers on CS_N/SCLK/SDO.
// Pins are one flop behind the FSM, so CS_N falls one edge after RUN is sampled; no backpressure.
module pattern_spi_streamer #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int CLK_DIV   = 4,
  parameter int GAP       = 2,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_EN,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             RUN,
  input  logic             LOOP,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic [AW-1:0]    CUR_ADDR,
  output logic             CS_N,
  output logic             SDO,
  output logic             SCLK
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int EW = $clog2(2 * WIDTH + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [EW-1:0]    edge_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] sh;
  logic [AW-1:0]    addr;
  logic             armed;
  logic             sclk_q;
  logic             sdo_q;
  logic             tick;
  logic [AW-1:0]    start_addr;
  logic [WIDTH-1:0] start_word;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign tick       = (div_cnt == DW'(CLK_DIV - 1));
  assign start_addr = (state == S_IDLE) ? '0 : addr + 1'b1;
  // Read happens before this edge's write lands, so a same-cycle write returns old data.
  assign start_word = mem[start_addr];

  always_ff @(posedge CLK) begin
    if (WR_EN) mem[WR_ADDR] <= WR_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      gap_cnt  <= '0;
      sh       <= '0;
      addr     <= '0;
      armed    <= 1'b1;
      sclk_q   <= CPOL;
      sdo_q    <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          if (!RUN) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= S_SETUP;
            addr  <= start_addr;
            sh    <= CPHA ? start_word : shifted(start_word);
            sdo_q <= CPHA ? 1'b0 : first_bit(start_word);
          end
        end
        S_SETUP: begin
          if (tick) begin
            state    <= S_SHIFT;
            sclk_q   <= ~CPOL;
            edge_cnt <= EW'(1);
            if (CPHA) begin
              sdo_q <= first_bit(sh);
              sh    <= shifted(sh);
            end
          end
        end
        S_SHIFT: begin
          if (tick) begin
            if (edge_cnt == EW'(2 * WIDTH)) begin
              state <= S_HOLD;
            end else begin
              sclk_q   <= ~sclk_q;
              edge_cnt <= edge_cnt + 1'b1;
              // Odd edges are trailing, even edges leading; the final trailing edge never advances.
              if ((edge_cnt[0] && !CPHA && edge_cnt != EW'(2 * WIDTH - 1)) ||
                  (!edge_cnt[0] && CPHA)) begin
                sdo_q <= first_bit(sh);
                sh    <= shifted(sh);
              end
            end
          end
        end
        S_HOLD: begin
          if (tick) begin
            state   <= S_GAP;
            sdo_q   <= 1'b0;
            gap_cnt <= '0;
          end
        end
        S_GAP: begin
          if (tick) begin
            if (gap_cnt != GW'(GAP - 1)) begin
              gap_cnt <= gap_cnt + 1'b1;
            end else if (!LOOP && addr == AW'(DEPTH - 1)) begin
              state <= S_IDLE;
              armed <= 1'b0;
            end else if (RUN) begin
              state <= S_SETUP;
              addr  <= start_addr;
              sh    <= CPHA ? start_word : shifted(start_word);
              sdo_q <= CPHA ? 1'b0 : first_bit(start_word);
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      CS_N       <= 1'b1;
      SCLK       <= CPOL;
      SDO        <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      CUR_ADDR   <= '0;
    end else begin
      CS_N       <= !(state == S_SETUP || state == S_SHIFT || state == S_HOLD);
      SCLK       <= sclk_q;
      SDO        <= sdo_q;
      BUSY       <= (state != S_IDLE);
      FRAME_DONE <= (state == S_GAP) && !CS_N;
      CUR_ADDR   <= addr;
    end
  end

endmodule

// File: tb/tb_pattern_spi_streamer.sv
// Scoreboarded bench: two streamer instances (mode 0 MSB-first, mode 3 LSB-first) decoded by slave monitors.
module tb_pattern_spi_streamer;

  localparam int W   = 16;
  localparam int CD0 = 4;
  localparam int G0  = 2;
  localparam int CD1 = 3;
  localparam int G1  = 3;
  localparam int P0  = CD0 * (2 * W + 2 + G0);
  localparam int P1  = CD1 * (2 * W + 2 + G1);

  typedef struct {
    logic [1:0]   addr;
    logic [W-1:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic wr0, run0, loop0, busy0, fd0, cs0, sdo0, sclk0;
  logic [1:0] wa0, ca0;
  logic [W-1:0] wd0;
  logic wr1, run1, loop1, busy1, fd1, cs1, sdo1, sclk1;
  logic [1:0] wa1, ca1;
  logic [W-1:0] wd1;

  pattern_spi_streamer #(.WIDTH(W), .DEPTH(4), .CLK_DIV(CD0), .GAP(G0),
                         .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u0 (
    .CLK(clk), .RST(rst), .WR_EN(wr0), .WR_ADDR(wa0), .WR_DATA(wd0), .RUN(run0),
    .LOOP(loop0), .BUSY(busy0), .FRAME_DONE(fd0), .CUR_ADDR(ca0), .CS_N(cs0),
    .SDO(sdo0), .SCLK(sclk0));

  pattern_spi_streamer #(.WIDTH(W), .DEPTH(4), .CLK_DIV(CD1), .GAP(G1),
                         .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u1 (
    .CLK(clk), .RST(rst), .WR_EN(wr1), .WR_ADDR(wa1), .WR_DATA(wd1), .RUN(run1),
    .LOOP(loop1), .BUSY(busy1), .FRAME_DONE(fd1), .CUR_ADDR(ca1), .CS_N(cs1),
    .SDO(sdo1), .SCLK(sclk1));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [W-1:0] ref0 [4];
  logic [W-1:0] ref1 [4];
  exp_t q0[$];
  exp_t q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Slave monitor for u0: mode 0, samples SDO on rising SCLK, MSB first.
  int falls0 = 0, fdn0 = 0, low0, edges0, last0;
  logic cs0_p = 1'b1, sclk0_p = 1'b0, act0 = 1'b0, chain0 = 1'b0, after0 = 1'b0, rise0;
  logic [W-1:0] rx0;
  logic [1:0] fa0;
  exp_t e0;
  always @(negedge clk) begin
    if (rst) begin
      act0 = 1'b0; chain0 = 1'b0; after0 = 1'b0;
    end else begin
      rise0 = cs0 && !cs0_p;
      if (after0) begin
        check("m0_gap_sdo", sdo0, 1'b0);
        check("m0_gap_sclk", sclk0, 1'b0);
        after0 = 1'b0;
      end
      if (fd0) fdn0++;
      if (fd0 || rise0) check("m0_fd_at_cs_rise", fd0, rise0);
      if (!cs0 && cs0_p) begin
        falls0++; act0 = 1'b1; low0 = 0; edges0 = 0; rx0 = '0; fa0 = ca0;
        check("m0_sclk_idle_at_fall", sclk0, 1'b0);
        if (chain0) check("m0_frame_period", cyc - last0, P0);
        last0 = cyc; chain0 = 1'b1;
      end
      if (!cs0) begin
        low0++;
        if (sclk0 != sclk0_p) begin
          edges0++;
          if (sclk0) rx0 = {rx0[W-2:0], sdo0};
        end
      end
      if (rise0 && act0) begin
        act0 = 1'b0; after0 = 1'b1;
        check("m0_sclk_edges", edges0, 2 * W);
        check("m0_cs_low_cycles", low0, CD0 * (2 * W + 2));
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL m0_unexpected_frame: addr=%0d data=0x%0h, no frame expected", fa0, rx0);
        end else begin
          e0 = q0.pop_front();
          check("m0_cur_addr", fa0, e0.addr);
          check("m0_data", rx0, e0.word);
        end
      end
      if (!busy0) chain0 = 1'b0;
    end
    cs0_p = cs0; sclk0_p = sclk0;
  end

  // Slave monitor for u1: mode 3, samples SDO on rising SCLK, LSB first.
  int falls1 = 0, fdn1 = 0, low1, edges1, last1;
  logic cs1_p = 1'b1, sclk1_p = 1'b1, act1 = 1'b0, chain1 = 1'b0, after1 = 1'b0, rise1;
  logic [W-1:0] rx1;
  logic [1:0] fa1;
  exp_t e1;
  always @(negedge clk) begin
    if (rst) begin
      act1 = 1'b0; chain1 = 1'b0; after1 = 1'b0;
    end else begin
      rise1 = cs1 && !cs1_p;
      if (after1) begin
        check("m1_gap_sdo", sdo1, 1'b0);
        check("m1_gap_sclk", sclk1, 1'b1);
        after1 = 1'b0;
      end
      if (fd1) fdn1++;
      if (fd1 || rise1) check("m1_fd_at_cs_rise", fd1, rise1);
      if (!cs1 && cs1_p) begin
        falls1++; act1 = 1'b1; low1 = 0; edges1 = 0; rx1 = '0; fa1 = ca1;
        check("m1_sclk_idle_at_fall", sclk1, 1'b1);
        if (chain1) check("m1_frame_period", cyc - last1, P1);
        last1 = cyc; chain1 = 1'b1;
      end
      if (!cs1) begin
        low1++;
        if (sclk1 != sclk1_p) begin
          edges1++;
          if (sclk1) rx1 = {sdo1, rx1[W-1:1]};
        end
      end
      if (rise1 && act1) begin
        act1 = 1'b0; after1 = 1'b1;
        check("m1_sclk_edges", edges1, 2 * W);
        check("m1_cs_low_cycles", low1, CD1 * (2 * W + 2));
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL m1_unexpected_frame: addr=%0d data=0x%0h, no frame expected", fa1, rx1);
        end else begin
          e1 = q1.pop_front();
          check("m1_cur_addr", fa1, e1.addr);
          check("m1_data", rx1, e1.word);
        end
      end
      if (!busy1) chain1 = 1'b0;
    end
    cs1_p = cs1; sclk1_p = sclk1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [1:0] a, input logic [W-1:0] d);
    exp_t e;
    e.addr = a; e.word = d;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [1:0] a, input logic [W-1:0] d);
    exp_t e;
    e.addr = a; e.word = d;
    q1.push_back(e);
  endtask

  task automatic write0(input logic [1:0] a, input logic [W-1:0] d);
    wr0 = 1'b1; wa0 = a; wd0 = d;
    step(1);
    wr0 = 1'b0; ref0[a] = d;
  endtask

  task automatic write1(input logic [1:0] a, input logic [W-1:0] d);
    wr1 = 1'b1; wa1 = a; wd1 = d;
    step(1);
    wr1 = 1'b0; ref1[a] = d;
  endtask

  task automatic wait_falls0(input int target, input int budget);
    int n = 0;
    while (falls0 < target && n < budget) begin step(1); n++; end
    check("wait_cs_fall_u0", falls0 >= target, 1'b1);
  endtask

  task automatic wait_falls1(input int target, input int budget);
    int n = 0;
    while (falls1 < target && n < budget) begin step(1); n++; end
    check("wait_cs_fall_u1", falls1 >= target, 1'b1);
  endtask

  task automatic wait_idle0(input int budget);
    int n = 0;
    while (busy0 && n < budget) begin step(1); n++; end
    check("wait_idle_u0", busy0, 1'b0);
  endtask

  task automatic wait_idle1(input int budget);
    int n = 0;
    while (busy1 && n < budget) begin step(1); n++; end
    check("wait_idle_u1", busy1, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int fb, fdb, n;
    logic [W-1:0] old0;
    rst = 1'b1;
    wr0 = 0; run0 = 0; loop0 = 0; wa0 = 0; wd0 = 0;
    wr1 = 0; run1 = 0; loop1 = 0; wa1 = 0; wd1 = 0;
    step(3);
    check("rst_cs_n_u0", cs0, 1'b1);
    check("rst_sclk_u0", sclk0, 1'b0);
    check("rst_sdo_u0", sdo0, 1'b0);
    check("rst_busy_u0", busy0, 1'b0);
    check("rst_fd_u0", fd0, 1'b0);
    check("rst_addr_u0", ca0, 2'd0);
    check("rst_cs_n_u1", cs1, 1'b1);
    check("rst_sclk_u1", sclk1, 1'b1);
    rst = 1'b0;

    write0(2'd0, 16'hA5C3);
    for (int i = 1; i < 4; i++) write0(2'(i), W'($urandom));
    write1(2'd0, 16'h0001);
    write1(2'd1, 16'h8000);
    write1(2'd2, 16'hFFFF);
    write1(2'd3, 16'h1234);

    // Start latency and a single pulsed one-shot frame on u0.
    push0(2'd0, ref0[0]);
    run0 = 1'b1;
    step(1);
    check("start_cs_still_high", cs0, 1'b1);
    step(1);
    check("start_cs_low", cs0, 1'b0);
    check("start_busy", busy0, 1'b1);
    run0 = 1'b0;
    wait_idle0(2 * P0);
    check("pulse_one_frame", fdn0, 1);

    // One-shot u1 with RUN held: four frames, then nothing more until RUN is dropped.
    for (int i = 0; i < 4; i++) push1(2'(i), ref1[i]);
    run1 = 1'b1;
    wait_falls1(4, 5 * P1);
    wait_idle1(2 * P1);
    check("oneshot_fd_count", fdn1, 4);
    step(3 * P1);
    check("oneshot_no_5th", falls1, 4);
    check("oneshot_stays_idle", busy1, 1'b0);
    run1 = 1'b0;
    step(2);
    for (int i = 0; i < 4; i++) push1(2'(i), ref1[i]);
    run1 = 1'b1;
    wait_falls1(8, 5 * P1);
    run1 = 1'b0;
    wait_idle1(2 * P1);
    check("replay_fd_count", fdn1, 8);

    // Looping u0 for ten frames.
    loop0 = 1'b1;
    fb = falls0; fdb = fdn0;
    for (int i = 0; i < 10; i++) push0(2'(i % 4), ref0[i % 4]);
    run0 = 1'b1;
    wait_falls0(fb + 10, 11 * P0);
    run0 = 1'b0;
    wait_idle0(2 * P0);
    check("loop10_fd_count", fdn0 - fdb, 10);

    // RUN dropped during frame 2: it completes, then idle.
    fb = falls0; fdb = fdn0;
    for (int i = 0; i < 3; i++) push0(2'(i), ref0[i]);
    run0 = 1'b1;
    wait_falls0(fb + 3, 4 * P0);
    run0 = 1'b0;
    wait_idle0(2 * P0);
    check("drop_fd_count", fdn0 - fdb, 3);

    // Restart from addr 0 with a write to addr 0 in the snapshot cycle: old data goes out.
    fb = falls0;
    old0 = ref0[0];
    push0(2'd0, old0);
    wr0 = 1'b1; wa0 = 2'd0; wd0 = 16'h3C3C; run0 = 1'b1;
    step(1);
    wr0 = 1'b0; ref0[0] = 16'h3C3C;
    wait_falls0(fb + 1, 2 * P0);
    run0 = 1'b0;
    wait_idle0(2 * P0);

    // Writes into a frame in flight only affect later visits.
    write0(2'd1, 16'h00FF);
    fb = falls0;
    push0(2'd0, ref0[0]); push0(2'd1, 16'h00FF); push0(2'd2, ref0[2]);
    push0(2'd3, ref0[3]); push0(2'd0, ref0[0]); push0(2'd1, 16'hFF00);
    run0 = 1'b1;
    wait_falls0(fb + 2, 3 * P0);
    write0(2'd1, 16'hFF00);
    wait_falls0(fb + 6, 6 * P0);
    write0(2'd1, 16'h5A5A);
    run0 = 1'b0;
    wait_idle0(2 * P0);

    // Reset in the middle of the addr-1 frame: abandoned, no FRAME_DONE, clean restart.
    loop0 = 1'b0;
    fb = falls0;
    push0(2'd0, ref0[0]);
    run0 = 1'b1;
    wait_falls0(fb + 2, 3 * P0);
    step(CD0 * 15);
    fdb = fdn0;
    rst = 1'b1;
    step(1);
    check("midrst_cs_n", cs0, 1'b1);
    check("midrst_sclk", sclk0, 1'b0);
    check("midrst_sdo", sdo0, 1'b0);
    check("midrst_busy", busy0, 1'b0);
    check("midrst_fd", fd0, 1'b0);
    check("midrst_addr", ca0, 2'd0);
    run0 = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);
    check("midrst_no_fd", fdn0, fdb);
    fb = falls0;
    push0(2'd0, ref0[0]);
    run0 = 1'b1;
    wait_falls0(fb + 1, 2 * P0);
    run0 = 1'b0;
    wait_idle0(2 * P0);

    // Randomised rounds: fresh contents, random loop length on u0, full one-shot on u1.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        write0(2'(i), W'($urandom));
        write1(2'(i), W'($urandom));
      end
      n = $urandom_range(1, 6);
      loop0 = 1'b1;
      fb = falls0; fdb = fdn0;
      for (int i = 0; i < n; i++) push0(2'(i % 4), ref0[i % 4]);
      run0 = 1'b1;
      wait_falls0(fb + n, (n + 1) * P0);
      run0 = 1'b0;
      wait_idle0(2 * P0);
      check("rand_loop_fd_count", fdn0 - fdb, n);
      fb = falls1; fdb = fdn1;
      for (int i = 0; i < 4; i++) push1(2'(i), ref1[i]);
      run1 = 1'b1;
      wait_falls1(fb + 4, 5 * P1);
      wait_idle1(2 * P1);
      run1 = 1'b0;
      step(2);
      check("rand_oneshot_fd_count", fdn1 - fdb, 4);
    end

    step(4);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
